// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and byte-enable helper for the data-memory responder
//
// Purpose: access-size and FSM-state enums plus the byte-enable builder used by
// dmem_responder when it drives the dmem_array write port.
// Contents: mem_size_t, dmem_state_t, byte_en().
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Lanes touched by an access of the given size at byte offset lane.
  // Size 3 is illegal and yields no lanes.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      MEM_B:   byte_en = 4'b0001 << lane;
      MEM_H:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
      MEM_W:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - synchronous word array with byte-enable write and registered read
//
// Purpose: DEPTH x 32-bit storage, no reset.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   be     in   4-bit byte-enable, bit i writes byte lane i
//   addr   in   word index
//   wdata  in   write data, already replicated onto the lanes
//   re     in   read enable; rdata holds its value when re is low
//   rdata  out  registered read data
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency responder for the core data-memory interface
//
// Purpose: accepts one load/store at a time on the req channel, performs it on
// a dmem_array after LATENCY cycles and returns data/error on the rsp channel.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (req_ready high only in IDLE)
//   req_addr, req_we,          byte address, store flag,
//   req_size, req_unsigned,    0=byte 1=half 2=word, zero-extend loads,
//   req_wdata                  right-aligned store data
//   rsp_valid / rsp_ready      response handshake
//   rsp_rdata, rsp_err         extended load data (0 for stores/errors), error flag
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  dmem_state_t state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;
  logic        load_ok_q;   // response carries array data (load without error)

  logic        err_c;
  logic        commit;
  logic [31:0] wlanes;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;

  always_comb begin
    err_c = (size_q == 2'd3) ||
            (size_q == MEM_H && addr_q[0]) ||
            (size_q == MEM_W && addr_q[1:0] != 2'd0) ||
            (addr_q >= ADDR_LIMIT);
  end

  // The edge that moves WAIT->RESP is the single commit edge for both
  // the store and the load read.
  assign commit = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
    case (size_q)
      MEM_B:   wlanes = {4{wdata_q[7:0]}};
      MEM_H:   wlanes = {2{wdata_q[15:0]}};
      default: wlanes = wdata_q;
    endcase
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (commit && we_q && !err_c),
    .be    (byte_en(size_q, addr_q[1:0])),
    .addr  (addr_q[AW+1:2]),
    .wdata (wlanes),
    .re    (commit && !we_q && !err_c),
    .rdata (rd_word)
  );

  // rd_word and the captured request are both frozen while in RESP, so the
  // extended value is stable through a stall; load_ok_q masks it to zero
  // after reset and for stores/errors.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      MEM_B:   ext = unsigned_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      MEM_H:   ext = unsigned_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ext = rd_word;
    endcase
    rsp_rdata = load_ok_q ? ext : 32'h0;
  end

  // WAIT is always visited so the array sees a captured request on the
  // commit edge; cnt = LATENCY-1 puts that edge LATENCY edges after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= 32'h0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      wdata_q    <= 32'h0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      load_ok_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            cnt        <= 4'(LATENCY - 1);
            req_ready  <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_c;
            load_ok_q <= !we_q && !err_c;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            load_ok_q <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at LATENCY 1, 2 and 15
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int NI    = 3;

  logic        clk = 1'b0;
  logic        rst_n        [NI];
  logic        req_valid    [NI];
  logic        req_ready    [NI];
  logic [31:0] req_addr     [NI];
  logic        req_we       [NI];
  logic [1:0]  req_size     [NI];
  logic        req_unsigned [NI];
  logic [31:0] req_wdata    [NI];
  logic        rsp_valid    [NI];
  logic        rsp_ready    [NI];
  logic [31:0] rsp_rdata    [NI];
  logic        rsp_err      [NI];

  int checks = 0;
  int errors = 0;

  logic [7:0] model [NI][DEPTH*4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (g == 0 ? 1 : (g == 1 ? 2 : 15))
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n[g]),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_addr     (req_addr[g]),
      .req_we       (req_we[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_unsigned[g]),
      .req_wdata    (req_wdata[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_err      (rsp_err[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 15);
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic exp_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr >= DEPTH * 4);
  endfunction

  function automatic logic [31:0] model_load(input int k, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
    logic [31:0] v = 32'h0;
    int n = nbytes(size);
    for (int i = 0; i < n; i++) v = v | (32'(model[k][addr + i]) << (8 * i));
    if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input int k, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
    for (int i = 0; i < nbytes(size); i++) model[k][addr + i] = wdata[8*i +: 8];
  endtask

  task automatic txn_accept(input int k, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    @(negedge clk);
    req_valid[k] = 1'b1;  req_we[k] = we;     req_size[k] = size;
    req_unsigned[k] = uns; req_addr[k] = addr; req_wdata[k] = wdata;
    while (req_ready[k] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL accept_timeout inst=%0d addr=%h: req_ready stayed low, required high", k, addr);
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic txn_wait(input int k, output int lat);
    lat = 0;
    while (rsp_valid[k] !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    if (rsp_valid[k] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL rsp_timeout inst=%0d: rsp_valid=%b after 40 edges, required 1", k, rsp_valid[k]);
    end
  endtask

  task automatic txn_finish(input int k);
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
  endtask

  task automatic do_txn(input int k, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    txn_accept(k, we, size, uns, addr, wdata);
    txn_wait(k, lat);
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
    txn_finish(k);
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== 32'h0 || rsp_err[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst=%0d: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                 k, req_ready[k], rsp_valid[k], rsp_rdata[k], rsp_err[k]);
      end
    end
  endtask

  task automatic test_basic(input int k);
    logic [31:0] d; logic e; int lat;
    do_txn(k, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, d, e, lat);
    checks++;
    if (e !== 1'b0 || d !== 32'h0 || lat != lat_of(k)) begin
      errors++;
      $display("FAIL sw_basic inst=%0d: err=%b rdata=%h lat=%0d, required 0 0 %0d", k, e, d, lat, lat_of(k));
    end
    do_txn(k, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, d, e, lat);
    checks++;
    if (e !== 1'b0 || d !== 32'hDEAD_BEEF || lat != lat_of(k)) begin
      errors++;
      $display("FAIL lw_basic inst=%0d: err=%b rdata=%h lat=%0d, required 0 deadbeef %0d", k, e, d, lat, lat_of(k));
    end
  endtask

  task automatic test_byte_lanes(input int k);
    logic [31:0] d; logic e; int lat;
    logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd2, 2'd1};
    logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad  [4] = '{32'h11, 32'h11, 32'h10, 32'h12};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hDEAD_80EF, 32'hFFFF_DEAD};
    do_txn(k, 1'b1, 2'd0, 1'b0, 32'h11, 32'h80, d, e, lat);
    for (int i = 0; i < 4; i++) begin
      do_txn(k, 1'b0, sz[i], un[i], ad[i], 32'h0, d, e, lat);
      checks++;
      if (d !== exp[i] || e !== 1'b0) begin
        errors++;
        $display("FAIL lane_load%0d inst=%0d: rdata=%h err=%b, required %h 0", i, k, d, e, exp[i]);
      end
    end
  endtask

  task automatic test_errors(input int k);
    logic [31:0] d; logic e; int lat;
    logic        we [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  sz [5] = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] ad [5] = '{32'h12, 32'h13, 32'(DEPTH*4), 32'h10, 32'h10};
    logic        ee [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ed [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hDEAD_80EF};
    for (int i = 0; i < 5; i++) begin
      do_txn(k, we[i], sz[i], 1'b0, ad[i], 32'h1234, d, e, lat);
      checks++;
      if (e !== ee[i] || d !== ed[i]) begin
        errors++;
        $display("FAIL error_case%0d inst=%0d: err=%b rdata=%h, required %b %h", i, k, e, d, ee[i], ed[i]);
      end
    end
  endtask

  task automatic test_stall(input int k);
    logic [31:0] d; logic e; int lat;
    txn_accept(k, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    txn_wait(k, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_valid[k] = 1'b1; req_we[k] = 1'b1; req_size[k] = 2'd2;
        req_addr[k] = 32'h10; req_wdata[k] = 32'h0;
      end
      if (i == 2) req_valid[k] = 1'b0;
      checks++;
      if (rsp_valid[k] !== 1'b1 || rsp_rdata[k] !== 32'hDEAD_80EF || rsp_err[k] !== 1'b0 || req_ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d inst=%0d: valid=%b rdata=%h err=%b ready=%b, required 1 dead80ef 0 0",
                 i, k, rsp_valid[k], rsp_rdata[k], rsp_err[k], req_ready[k]);
      end
    end
    txn_finish(k);
    checks++;
    if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL stall_release inst=%0d: valid=%b ready=%b, required 0 1", k, rsp_valid[k], req_ready[k]);
    end
    do_txn(k, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, d, e, lat);
    checks++;
    if (d !== 32'hDEAD_80EF) begin
      errors++;
      $display("FAIL stall_store_ignored inst=%0d: rdata=%h, required dead80ef", k, d);
    end
  endtask

  task automatic test_back_to_back(input int k);
    logic [31:0] dat [4];
    logic [31:0] d; logic e; int lat;
    int edges = 0, acc = 0, hs = 0, prev_hs = 0, n;
    for (int i = 0; i < 4; i++) dat[i] = $urandom;
    rsp_ready[k] = 1'b1;
    req_valid[k] = 1'b1; req_we[k] = 1'b1; req_size[k] = 2'd2; req_unsigned[k] = 1'b0;
    req_addr[k] = 32'h40; req_wdata[k] = dat[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n = 0;
      while (req_ready[k] !== 1'b1 && n < 100) begin @(posedge clk); edges++; @(negedge clk); n++; end
      @(posedge clk); edges++; acc = edges;
      if (i > 0) begin
        checks++;
        if (acc - prev_hs != 1) begin
          errors++;
          $display("FAIL b2b_gap%0d inst=%0d: %0d edges handshake->accept, required 1", i, k, acc - prev_hs);
        end
      end
      @(negedge clk);
      n = 0;
      while (rsp_valid[k] !== 1'b1 && n < 100) begin @(posedge clk); edges++; @(negedge clk); n++; end
      @(posedge clk); edges++; hs = edges; #1;
      checks++;
      if (hs - acc != lat_of(k) + 1) begin
        errors++;
        $display("FAIL b2b_complete%0d inst=%0d: %0d edges, required %0d", i, k, hs - acc, lat_of(k) + 1);
      end
      model_store(k, 2'd2, 32'h40 + 32'(4 * i), dat[i]);
      if (i < 3) begin
        req_addr[k] = 32'h40 + 32'(4 * (i + 1)); req_wdata[k] = dat[i + 1];
      end else begin
        req_valid[k] = 1'b0;
      end
      prev_hs = hs;
    end
    rsp_ready[k] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_txn(k, 1'b0, 2'd2, 1'b0, 32'h40 + 32'(4 * i), 32'h0, d, e, lat);
      checks++;
      if (d !== model_load(k, 2'd2, 1'b0, 32'h40 + 32'(4 * i)) || e !== 1'b0) begin
        errors++;
        $display("FAIL b2b_readback%0d inst=%0d: rdata=%h err=%b, required %h 0", i, k, d, e, dat[i]);
      end
    end
  endtask

  task automatic test_reset_mid_wait(input int k);
    logic [31:0] d; logic e; int lat;
    do_txn(k, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, d, e, lat);
    txn_accept(k, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1111_1111);
    @(negedge clk);
    rst_n[k] = 1'b0;
    #1;
    checks++;
    if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== 32'h0 || rsp_err[k] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset inst=%0d: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
               k, req_ready[k], rsp_valid[k], rsp_rdata[k], rsp_err[k]);
    end
    @(negedge clk);
    rst_n[k] = 1'b1;
    do_txn(k, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, d, e, lat);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_store inst=%0d: rdata=%h err=%b, required 0 0", k, d, e);
    end
  endtask

  task automatic test_random(input int k);
    logic [31:0] d, addr, wdata, exp_d; logic e, we, uns, ee; logic [1:0] size; int lat;
    for (int i = 0; i < 16; i++) begin
      wdata = $urandom;
      do_txn(k, 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * i), wdata, d, e, lat);
      model_store(k, 2'd2, 32'h100 + 32'(4 * i), wdata);
    end
    for (int i = 0; i < 40; i++) begin
      we    = 1'($urandom % 2);
      uns   = 1'($urandom % 2);
      size  = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      wdata = $urandom;
      addr  = ($urandom % 8 == 0) ? 32'(DEPTH * 4) + ($urandom % 64) : 32'h100 + ($urandom % 64);
      if ($urandom % 4 != 0 && size != 2'd3) addr = addr - (addr % 32'(nbytes(size)));
      ee    = exp_err(size, addr);
      exp_d = (ee || we) ? 32'h0 : model_load(k, size, uns, addr);
      do_txn(k, we, size, uns, addr, wdata, d, e, lat);
      if (!ee && we) model_store(k, size, addr, wdata);
      checks++;
      if (d !== exp_d || e !== ee || lat != lat_of(k)) begin
        errors++;
        $display("FAIL random%0d inst=%0d we=%b size=%0d addr=%h: rdata=%h err=%b lat=%0d, required %h %b %0d",
                 i, k, we, size, addr, d, e, lat, exp_d, ee, lat_of(k));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_addr[k] = 32'h0; req_we[k] = 1'b0;
      req_size[k] = 2'd0; req_unsigned[k] = 1'b0; req_wdata[k] = 32'h0; rsp_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    @(posedge clk); #1;
    test_reset();
    for (int k = 0; k < NI; k++) begin
      test_basic(k);
      test_byte_lanes(k);
      test_errors(k);
      test_stall(k);
      test_back_to_back(k);
      test_reset_mid_wait(k);
      test_random(k);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
